// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler that shares one external add/sub ALU among NUM_REQ requesters.
// One operation in flight: IDLE (grant) -> EXEC (capture ALU result) -> RESP (hold until taken).
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    input  logic [NUM_REQ-1:0]          req_mode,
    output logic [DATA_W-1:0]           alu_a,
    output logic [DATA_W-1:0]           alu_b,
    output logic                        alu_mode,
    input  logic [DATA_W:0]             alu_result,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [DATA_W:0]             rsp_result,
    output logic                        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     w_grant_id;
    logic                w_grant_found;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic                r_alu_mode;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W:0]     r_rsp_result;
    logic                w_accept;
    logic                w_rsp_done;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int unsigned      off);
        int unsigned s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return ID_W'(s);
    endfunction

    // Priority search starting at r_rr_ptr and wrapping past NUM_REQ-1.
    always_comb begin
        logic [ID_W-1:0] w_idx;
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        w_idx         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = wrap_idx(r_rr_ptr, i);
            if (!w_grant_found && req_valid[w_idx]) begin
                w_grant_found = 1'b1;
                w_grant_id    = w_idx;
            end
        end
    end

    always_comb begin
        if (w_grant_id == ID_W'(NUM_REQ - 1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_grant_id + 1'b1;
        end
    end

    assign w_accept   = (r_state == S_IDLE) && w_grant_found;
    assign w_rsp_done = (r_state == S_RESP) && r_rsp_valid && rsp_ready;

    // Ready is masked by rst_n so nothing looks accepted while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && w_accept) begin
            req_ready[w_grant_id] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_found) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_mode   <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_valid  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a    <= req_a[w_grant_id*DATA_W +: DATA_W];
                r_alu_b    <= req_b[w_grant_id*DATA_W +: DATA_W];
                r_alu_mode <= req_mode[w_grant_id];
                r_rsp_id   <= w_grant_id;
                r_rr_ptr   <= w_ptr_nxt;
            end
            if (r_state == S_EXEC) begin
                r_rsp_result <= alu_result;
                r_rsp_valid  <= 1'b1;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_mode   = r_alu_mode;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: vector table of single ops plus
// round-robin, backpressure, wrap-skip and mid-operation reset sequences.
module tb_alu_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 4;
    localparam int ID_W    = 2;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_mode;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic                      alu_mode;
    logic [DATA_W:0]           alu_result;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W:0]           rsp_result;
    logic                      busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
    );

    // External ALU that the scheduler drives.
    always_comb begin
        if (alu_mode) alu_result = {1'b0, alu_a} - {1'b0, alu_b};
        else          alu_result = {1'b0, alu_a} + {1'b0, alu_b};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic       mode;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int idx, input logic [3:0] a, input logic [3:0] b,
                           input logic m);
        req_a[idx*DATA_W +: DATA_W] = a;
        req_b[idx*DATA_W +: DATA_W] = b;
        req_mode[idx]               = m;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for rsp_valid, checks the response, leaves it for rsp_ready.
    task automatic wait_rsp(input string name, input int exp_id, input logic [4:0] exp_res);
        int n;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            chk({name, "_timeout"}, 32'(rsp_valid), 32'd1);
        end else begin
            chk({name, "_id"}, 32'(rsp_id), 32'(exp_id));
            chk({name, "_res"}, 32'(rsp_result), 32'(exp_res));
        end
    endtask

    // Single-requester operation with rsp_ready=1; checks ready, latency and result.
    task automatic do_op(input string name, input int idx, input logic [3:0] a,
                         input logic [3:0] b, input logic m, input logic [4:0] exp);
        @(negedge clk);
        set_req(idx, a, b, m);
        req_valid = NUM_REQ'(1) << idx;
        rsp_ready = 1'b1;
        #1 chk({name, "_ready"}, 32'(req_ready), 32'(NUM_REQ'(1) << idx));
        @(posedge clk);
        #1 req_valid = '0;
        chk({name, "_alu_a"}, 32'(alu_a), 32'(a));
        chk({name, "_alu_b"}, 32'(alu_b), 32'(b));
        chk({name, "_busy"}, 32'(busy), 32'd1);
        chk({name, "_early"}, 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_id"}, 32'(rsp_id), 32'(idx));
        chk({name, "_res"}, 32'(rsp_result), 32'(exp));
        @(posedge clk);
        #1 chk({name, "_done"}, 32'(rsp_valid), 32'd0);
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic m);
        return m ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

    initial begin
        int grants[$];
        int gcyc[$];
        logic [3:0] ra[4];
        logic [3:0] rb[4];
        logic       rm[4];

        vecs[0] = '{0, 4'd9,  4'd8,  1'b0, 5'h11};
        vecs[1] = '{2, 4'd3,  4'd5,  1'b1, 5'h1E};
        vecs[2] = '{1, 4'd15, 4'd15, 1'b0, 5'h1E};
        vecs[3] = '{3, 4'd0,  4'd1,  1'b1, 5'h1F};
        vecs[4] = '{3, 4'd15, 4'd0,  1'b1, 5'h0F};
        vecs[5] = '{1, 4'd0,  4'd0,  1'b0, 5'h00};
        vecs[6] = '{2, 4'd8,  4'd8,  1'b1, 5'h00};
        vecs[7] = '{0, 4'd7,  4'd3,  1'b1, 5'h04};

        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '1;
        req_b     = '1;
        req_mode  = '1;
        rsp_ready = 1'b0;
        #2;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_outs", 32'({alu_a, alu_b, alu_mode, rsp_id, rsp_result}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        do_reset();

        foreach (vecs[k]) begin
            do_op($sformatf("vec%0d", k), vecs[k].idx, vecs[k].a, vecs[k].b,
                  vecs[k].mode, vecs[k].exp);
        end

        // Round-robin with every requester valid from reset.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            ra[i] = 4'(i + 5);
            rb[i] = 4'(i * 3);
            rm[i] = i[0];
            set_req(i, ra[i], rb[i], rm[i]);
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && grants.size() < 5; cyc++) begin
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    grants.push_back(i);
                    gcyc.push_back(cyc);
                end
            end
            if (rsp_valid) begin
                chk("rr_res", 32'(rsp_result), 32'(ref_alu(ra[rsp_id], rb[rsp_id], rm[rsp_id])));
            end
            @(negedge clk);
        end
        req_valid = '0;
        chk("rr_count", 32'(grants.size()), 32'd5);
        if (grants.size() == 5) begin
            chk("rr_first", 32'(gcyc[0]), 32'd0);
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("rr_grant%0d", k), 32'(grants[k]), 32'(k % NUM_REQ));
                if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'd3);
            end
        end
        repeat (4) @(negedge clk);

        // Backpressure: response held while rsp_ready is low.
        do_reset();
        set_req(1, 4'd7, 4'd9, 1'b1);
        set_req(0, 4'd1, 4'd2, 1'b0);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 4'b0001;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_res", 32'(rsp_result), 32'h1E);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_done", 32'(rsp_valid), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp("bp_second", 0, 5'h03);
        repeat (2) @(negedge clk);

        // Wrap skip: pointer at 3, only requester 1 valid.
        do_reset();
        do_op("ws_setup", 2, 4'd1, 4'd1, 1'b0, 5'h02);
        @(negedge clk);
        set_req(1, 4'd4, 4'd6, 1'b0);
        req_valid = 4'b0010;
        #1 chk("ws_grant1", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp("ws_rsp1", 1, 5'h0A);
        @(negedge clk);
        @(negedge clk);
        set_req(3, 4'd2, 4'd3, 1'b1);
        req_valid = 4'b1010;
        #1 chk("ws_from2", 32'(req_ready), 32'b1000);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp("ws_rsp3", 3, 5'h1F);
        repeat (2) @(negedge clk);

        // Reset while in EXEC drops the operation and restarts the pointer.
        do_reset();
        do_op("re_setup", 2, 4'd9, 4'd4, 1'b1, 5'h05);
        @(negedge clk);
        set_req(2, 4'd9, 4'd4, 1'b0);
        set_req(0, 4'd6, 4'd6, 1'b0);
        req_valid = 4'b0100;
        @(posedge clk);
        #1 chk("re_in_exec", 32'(busy), 32'd1);
        rst_n     = 1'b0;
        req_valid = '1;
        #1;
        chk("re_outs", 32'({alu_a, alu_b, alu_mode, rsp_id, rsp_result}), 32'd0);
        chk("re_valid", 32'(rsp_valid), 32'd0);
        chk("re_ready", 32'(req_ready), 32'd0);
        chk("re_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("re_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("re_grant0", 32'(req_ready), 32'b0001);
        chk("re_no_rsp2", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp("re_rsp0", 0, 5'h0C);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
